// File: rtl/uc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uc_pkg
//  Description : Shared definitions for the multi-cycle control unit:
//                state encoding, opcode/funct3 constants, instruction
//                classes, ULA operation codes and write-back source codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package uc_pkg;

    // FSM state encoding
    localparam logic [2:0] c_ST_BUSCA      = 3'd0;
    localparam logic [2:0] c_ST_DECODIFICA = 3'd1;
    localparam logic [2:0] c_ST_EXECUTA    = 3'd2;
    localparam logic [2:0] c_ST_MEMORIA    = 3'd3;
    localparam logic [2:0] c_ST_ESCRITA    = 3'd4;
    localparam logic [2:0] c_ST_ERRO       = 3'd5;

    // Opcodes
    localparam logic [6:0] c_OP_TIPO_R  = 7'b0110011;
    localparam logic [6:0] c_OP_IMM     = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD    = 7'b0000011;
    localparam logic [6:0] c_OP_STORE   = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL     = 7'b1101111;

    // funct3 values
    localparam logic [2:0] c_F3_ADD_SUB = 3'b000;
    localparam logic [2:0] c_F3_LD_SD   = 3'b011;
    localparam logic [2:0] c_F3_BEQ     = 3'b000;
    localparam logic [2:0] c_F3_BLT     = 3'b100;
    localparam logic [2:0] c_F3_BGEU    = 3'b111;

    // Instruction classes (CL_NENHUMA also marks an illegal encoding)
    typedef enum logic [3:0] {
        CL_NENHUMA = 4'd0,
        CL_ADD     = 4'd1,
        CL_SUB     = 4'd2,
        CL_ADDI    = 4'd3,
        CL_LD      = 4'd4,
        CL_SD      = 4'd5,
        CL_BEQ     = 4'd6,
        CL_BLT     = 4'd7,
        CL_BGEU    = 4'd8,
        CL_JAL     = 4'd9
    } classe_t;

    // soma_ou_subtrai codes
    localparam logic [1:0] c_NAO     = 2'd0;
    localparam logic [1:0] c_SOMA    = 2'd1;
    localparam logic [1:0] c_SUBTRAI = 2'd2;

    // wb_sel codes
    localparam logic [1:0] c_WB_ULA = 2'd0;
    localparam logic [1:0] c_WB_MEM = 2'd1;
    localparam logic [1:0] c_WB_PC4 = 2'd2;

    function automatic logic eh_desvio(input classe_t i_classe);
        return (i_classe == CL_BEQ) || (i_classe == CL_BLT) || (i_classe == CL_BGEU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uc_decodificador.sv
`default_nettype none
// ============================================================================
//  Module      : uc_decodificador
//  Description : Purely combinational instruction classifier.
//  Ports       : i_opcode   - instruction opcode (7 bits)
//                i_funct3   - funct3 field
//                i_funct7_5 - instruction bit 30 (add/sub select)
//                o_classe   - instruction class (uc_pkg::classe_t encoding)
//                o_legal    - 1 when the encoding is supported
//  Revision    : 1.0 - initial release
// ============================================================================
module uc_decodificador
    import uc_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_classe,
    output logic       o_legal
);

    classe_t w_classe;

    always_comb begin
        w_classe = CL_NENHUMA;
        case (i_opcode)
            c_OP_TIPO_R: begin
                if (i_funct3 == c_F3_ADD_SUB) begin
                    w_classe = i_funct7_5 ? CL_SUB : CL_ADD;
                end
            end
            c_OP_IMM: begin
                if (i_funct3 == c_F3_ADD_SUB) begin
                    w_classe = CL_ADDI;
                end
            end
            c_OP_LOAD: begin
                if (i_funct3 == c_F3_LD_SD) begin
                    w_classe = CL_LD;
                end
            end
            c_OP_STORE: begin
                if (i_funct3 == c_F3_LD_SD) begin
                    w_classe = CL_SD;
                end
            end
            c_OP_BRANCH: begin
                case (i_funct3)
                    c_F3_BEQ:  w_classe = CL_BEQ;
                    c_F3_BLT:  w_classe = CL_BLT;
                    c_F3_BGEU: w_classe = CL_BGEU;
                    default:   w_classe = CL_NENHUMA;
                endcase
            end
            // jal ignores funct3: that field is part of its immediate
            c_OP_JAL: w_classe = CL_JAL;
            default:  w_classe = CL_NENHUMA;
        endcase
    end

    assign o_classe = w_classe;
    assign o_legal  = (w_classe != CL_NENHUMA);

endmodule
`default_nettype wire

// File: rtl/uc_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : uc_multiciclo
//  Description : Multi-cycle control unit (BUSCA, DECODIFICA, EXECUTA,
//                MEMORIA, ESCRITA, ERRO). All outputs are combinational
//                from the state, the registered class and the flags, and
//                are forced to 0 while reset is high.
//  Parameter   : TIMEOUT - cycles waiting for mem_ack before ERRO
//  Macro       : UC_TIMEOUT_EN - enables the mem_ack wait watchdog
//  Ports       : clk, reset (sync, active-high)
//                opcode/funct3/funct7_5 - from the external IR
//                flag_igual/flag_menor/flag_maior_igual_u - ULA compare
//                mem_ack - memory transfer complete
//                soma_ou_subtrai, usa_imm - ULA control
//                carrega_ir, carrega_pc, escreve_reg - load enables
//                pc_src, mem_req, mem_we, mem_addr_sel, wb_sel - datapath
//                ilegal - sticky error indication
//  Revision    : 1.0 - initial release
// ============================================================================
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int TIMEOUT = 16
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       flag_igual,
    input  logic       flag_menor,
    input  logic       flag_maior_igual_u,
    input  logic       mem_ack,
    output logic [1:0] soma_ou_subtrai,
    output logic       usa_imm,
    output logic       carrega_ir,
    output logic       carrega_pc,
    output logic       escreve_reg,
    output logic       pc_src,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic [1:0] wb_sel,
    output logic       ilegal
);

    logic [2:0] r_estado;
    logic [2:0] w_prox_base;
    logic [2:0] w_proximo;
    classe_t    r_classe;
    logic [3:0] w_classe_dec;
    logic       w_legal;
    logic       w_mem_req;
    logic       w_estouro;

    logic [1:0] w_ula_op;
    logic       w_ula_imm;
    logic       w_tomado;

    logic [1:0] w_soma;
    logic       w_imm;
    logic       w_cir;
    logic       w_cpc;
    logic       w_wr;
    logic       w_pcs;
    logic       w_we;
    logic       w_asel;
    logic [1:0] w_wb;
    logic       w_il;

    uc_decodificador u_decodificador (
        .i_opcode   (opcode),
        .i_funct3   (funct3),
        .i_funct7_5 (funct7_5),
        .o_classe   (w_classe_dec),
        .o_legal    (w_legal)
    );

    assign w_mem_req = (r_estado == c_ST_BUSCA) || (r_estado == c_ST_MEMORIA);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_prox_base = r_estado;
        case (r_estado)
            c_ST_BUSCA: begin
                if (mem_ack) begin
                    w_prox_base = c_ST_DECODIFICA;
                end
            end
            c_ST_DECODIFICA: w_prox_base = w_legal ? c_ST_EXECUTA : c_ST_ERRO;
            c_ST_EXECUTA: begin
                case (r_classe)
                    CL_ADD, CL_SUB, CL_ADDI:         w_prox_base = c_ST_ESCRITA;
                    CL_LD, CL_SD:                    w_prox_base = c_ST_MEMORIA;
                    CL_BEQ, CL_BLT, CL_BGEU, CL_JAL: w_prox_base = c_ST_BUSCA;
                    default:                         w_prox_base = c_ST_ERRO;
                endcase
            end
            c_ST_MEMORIA: begin
                if (mem_ack) begin
                    w_prox_base = (r_classe == CL_SD) ? c_ST_BUSCA : c_ST_ESCRITA;
                end
            end
            c_ST_ESCRITA: w_prox_base = c_ST_BUSCA;
            c_ST_ERRO:    w_prox_base = c_ST_ERRO;
            default:      w_prox_base = c_ST_ERRO;
        endcase
    end

    assign w_proximo = w_estouro ? c_ST_ERRO : w_prox_base;

`ifdef UC_TIMEOUT_EN
    // Watchdog: counts consecutive waiting cycles; the cycle in which the
    // count would reach TIMEOUT redirects the FSM to ERRO.
    localparam int c_LARG_CNT = $clog2(TIMEOUT + 1);

    logic [c_LARG_CNT-1:0] r_cnt_espera;

    assign w_estouro = w_mem_req && !mem_ack &&
                       (r_cnt_espera == c_LARG_CNT'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_espera <= '0;
        end else if (!w_mem_req || mem_ack || (w_proximo != r_estado)) begin
            r_cnt_espera <= '0;
        end else begin
            r_cnt_espera <= r_cnt_espera + 1'b1;
        end
    end
`else
    assign w_estouro = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and class registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= c_ST_BUSCA;
            r_classe <= CL_NENHUMA;
        end else begin
            r_estado <= w_proximo;
            if (r_estado == c_ST_DECODIFICA) begin
                r_classe <= classe_t'(w_classe_dec);
            end
        end
    end

    // ULA operands for arithmetic/memory classes; reused in ESCRITA so the
    // ULA result stays stable while it is written back.
    always_comb begin
        w_ula_op  = c_NAO;
        w_ula_imm = 1'b0;
        case (r_classe)
            CL_ADD:               w_ula_op = c_SOMA;
            CL_SUB:               w_ula_op = c_SUBTRAI;
            CL_ADDI, CL_LD, CL_SD: begin
                w_ula_op  = c_SOMA;
                w_ula_imm = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_tomado = 1'b0;
        case (r_classe)
            CL_BEQ:  w_tomado = flag_igual;
            CL_BLT:  w_tomado = flag_menor;
            CL_BGEU: w_tomado = flag_maior_igual_u;
            default: w_tomado = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_soma = c_NAO;
        w_imm  = 1'b0;
        w_cir  = 1'b0;
        w_cpc  = 1'b0;
        w_wr   = 1'b0;
        w_pcs  = 1'b0;
        w_we   = 1'b0;
        w_asel = 1'b0;
        w_wb   = c_WB_ULA;
        w_il   = 1'b0;
        case (r_estado)
            c_ST_BUSCA: w_cir = mem_ack;
            c_ST_EXECUTA: begin
                if (eh_desvio(r_classe)) begin
                    w_soma = c_SUBTRAI;
                    w_cpc  = 1'b1;
                    w_pcs  = w_tomado;
                end else if (r_classe == CL_JAL) begin
                    w_wr  = 1'b1;
                    w_wb  = c_WB_PC4;
                    w_cpc = 1'b1;
                    w_pcs = 1'b1;
                end else begin
                    w_soma = w_ula_op;
                    w_imm  = w_ula_imm;
                end
            end
            c_ST_MEMORIA: begin
                w_asel = 1'b1;
                w_soma = c_SOMA;
                w_imm  = 1'b1;
                w_we   = (r_classe == CL_SD);
                w_cpc  = mem_ack && (r_classe == CL_SD);
            end
            c_ST_ESCRITA: begin
                w_wr   = 1'b1;
                w_wb   = (r_classe == CL_LD) ? c_WB_MEM : c_WB_ULA;
                w_cpc  = 1'b1;
                w_soma = w_ula_op;
                w_imm  = w_ula_imm;
            end
            c_ST_ERRO: w_il = 1'b1;
            default: ;
        endcase
    end

    // Reset masks every output so an aborted access never loads PC/regs.
    assign soma_ou_subtrai = reset ? c_NAO : w_soma;
    assign usa_imm         = w_imm     & ~reset;
    assign carrega_ir      = w_cir     & ~reset;
    assign carrega_pc      = w_cpc     & ~reset;
    assign escreve_reg     = w_wr      & ~reset;
    assign pc_src          = w_pcs     & ~reset;
    assign mem_req         = w_mem_req & ~reset;
    assign mem_we          = w_we      & ~reset;
    assign mem_addr_sel    = w_asel    & ~reset;
    assign wb_sel          = reset ? c_WB_ULA : w_wb;
    assign ilegal          = w_il      & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_uc_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uc_multiciclo
//  Description : Self-checking bench for uc_multiciclo: decode/latency
//                table, hand-written multi-cycle sequences and randomized
//                instruction streams checked against a phase-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_multiciclo;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       flag_igual = 1'b0, flag_menor = 1'b0, flag_maior_igual_u = 1'b0;
    logic       mem_ack = 1'b0;
    logic [1:0] soma_ou_subtrai, wb_sel;
    logic       usa_imm, carrega_ir, carrega_pc, escreve_reg, pc_src;
    logic       mem_req, mem_we, mem_addr_sel, ilegal;

    int n_chk = 0;
    int n_fail = 0;

    uc_multiciclo #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .flag_igual(flag_igual), .flag_menor(flag_menor),
        .flag_maior_igual_u(flag_maior_igual_u), .mem_ack(mem_ack),
        .soma_ou_subtrai(soma_ou_subtrai), .usa_imm(usa_imm),
        .carrega_ir(carrega_ir), .carrega_pc(carrega_pc),
        .escreve_reg(escreve_reg), .pc_src(pc_src), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .wb_sel(wb_sel),
        .ilegal(ilegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] soma; logic imm; logic cir; logic cpc; logic wr; logic pcs;
        logic req; logic we; logic asel; logic [1:0] wb; logic il;
    } out_t;

    typedef enum int {K_ADD, K_SUB, K_ADDI, K_LD, K_SD, K_BEQ, K_BLT, K_BGEU, K_JAL, K_ILL} kind_t;
    typedef enum int {P_FW, P_FA, P_DEC, P_EXE, P_MW, P_MA, P_WB, P_ERR} phase_t;

    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic f7;
        logic fi; logic fm; logic fg;
        int lat; logic pcs; int nwr; logic il;
    } vec_t;

    logic [6:0] enc_op [9] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b1100011, 7'b1100011, 7'b1101111};
    logic [2:0] enc_f3 [9] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd0, 3'd4, 3'd7, 3'd0};
    logic       enc_f7 [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic out_t dut_out();
        out_t o;
        o.soma = soma_ou_subtrai; o.imm = usa_imm; o.cir = carrega_ir;
        o.cpc = carrega_pc; o.wr = escreve_reg; o.pcs = pc_src; o.req = mem_req;
        o.we = mem_we; o.asel = mem_addr_sel; o.wb = wb_sel; o.il = ilegal;
        return o;
    endfunction

    function automatic kind_t classify(logic [6:0] op, logic [2:0] f3, logic f7);
        case (op)
            7'b0110011: return (f3 != 3'd0) ? K_ILL : (f7 ? K_SUB : K_ADD);
            7'b0010011: return (f3 == 3'd0) ? K_ADDI : K_ILL;
            7'b0000011: return (f3 == 3'd3) ? K_LD : K_ILL;
            7'b0100011: return (f3 == 3'd3) ? K_SD : K_ILL;
            7'b1100011: return (f3 == 3'd0) ? K_BEQ : (f3 == 3'd4) ? K_BLT :
                               (f3 == 3'd7) ? K_BGEU : K_ILL;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    // Expected outputs for one cycle of a given instruction phase
    function automatic out_t exp_out(phase_t ph, kind_t k, logic fi, logic fm, logic fg);
        out_t o;
        logic [1:0] aop;
        logic aimm;
        o = '0;
        aop  = (k == K_SUB) ? 2'd2 : ((k == K_ADD || k == K_ADDI || k == K_LD || k == K_SD) ? 2'd1 : 2'd0);
        aimm = (k == K_ADDI || k == K_LD || k == K_SD);
        case (ph)
            P_FW: o.req = 1'b1;
            P_FA: begin o.req = 1'b1; o.cir = 1'b1; end
            P_DEC: ;
            P_EXE: begin
                if (k == K_JAL) begin
                    o.wr = 1'b1; o.wb = 2'd2; o.cpc = 1'b1; o.pcs = 1'b1;
                end else if (k == K_BEQ || k == K_BLT || k == K_BGEU) begin
                    o.soma = 2'd2; o.cpc = 1'b1;
                    o.pcs = (k == K_BEQ) ? fi : (k == K_BLT) ? fm : fg;
                end else begin
                    o.soma = aop; o.imm = aimm;
                end
            end
            P_MW, P_MA: begin
                o.req = 1'b1; o.asel = 1'b1; o.soma = 2'd1; o.imm = 1'b1;
                o.we = (k == K_SD); o.cpc = (ph == P_MA) && (k == K_SD);
            end
            P_WB: begin
                o.wr = 1'b1; o.wb = (k == K_LD) ? 2'd1 : 2'd0; o.cpc = 1'b1;
                o.soma = aop; o.imm = aimm;
            end
            P_ERR: o.il = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic check(input string nm, input out_t got, input out_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ack = 1'($urandom);
        @(negedge clk);
        check("reset_outputs", dut_out(), '0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_instr(input int id, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int wf, input int wm);
        kind_t k;
        phase_t q[$];
        phase_t ph;
        out_t e;
        k = classify(op, f3, f7);
        repeat (wf) q.push_back(P_FW);
        q.push_back(P_FA);
        q.push_back(P_DEC);
        if (k == K_ILL) begin
            repeat (3) q.push_back(P_ERR);
        end else begin
            q.push_back(P_EXE);
            if (k == K_LD || k == K_SD) begin
                repeat (wm) q.push_back(P_MW);
                q.push_back(P_MA);
            end
            if (k == K_ADD || k == K_SUB || k == K_ADDI || k == K_LD) q.push_back(P_WB);
        end
        opcode = op; funct3 = f3; funct7_5 = f7;
        while (q.size() > 0) begin
            ph = q.pop_front();
            if (ph == P_FW || ph == P_MW)      mem_ack = 1'b0;
            else if (ph == P_FA || ph == P_MA) mem_ack = 1'b1;
            else                               mem_ack = 1'($urandom);
            flag_igual = 1'($urandom); flag_menor = 1'($urandom);
            flag_maior_igual_u = 1'($urandom);
            e = exp_out(ph, k, flag_igual, flag_menor, flag_maior_igual_u);
            @(negedge clk);
            check($sformatf("rnd%0d_k%0d_ph%0d", id, k, ph), dut_out(), e);
            @(posedge clk);
            #1;
        end
        if (k == K_ILL) do_reset();
    endtask

    initial begin
        vec_t tab[18];
        out_t e;
        int lat, nwr, cnt, first;
        logic pcs, ils, cpc_seen;
        logic [6:0] op;
        logic [2:0] f3;
        logic f7;
        int idx;

        tab[0]  = '{7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1, 1'b0};
        tab[1]  = '{7'b0110011, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b0, 1, 1'b0};
        tab[2]  = '{7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1, 1'b0};
        tab[3]  = '{7'b0000011, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1, 1'b0};
        tab[4]  = '{7'b0100011, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 4, 1'b0, 0, 1'b0};
        tab[5]  = '{7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 0, 1'b0};
        tab[6]  = '{7'b1100011, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0, 0, 1'b0};
        tab[7]  = '{7'b1100011, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1, 0, 1'b0};
        tab[8]  = '{7'b1100011, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0};
        tab[9]  = '{7'b1100011, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 0, 1'b0};
        tab[10] = '{7'b1100011, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b0, 0, 1'b0};
        tab[11] = '{7'b1101111, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1, 1'b0};
        tab[12] = '{7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1};
        tab[13] = '{7'b0110011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1};
        tab[14] = '{7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1};
        tab[15] = '{7'b1100011, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0, 1'b1};
        tab[16] = '{7'b0100011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1};
        tab[17] = '{7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1};

        // ---------------- table: zero-wait latency / decode ----------------
        for (int r = 0; r < 18; r++) begin
            do_reset();
            opcode = tab[r].op; funct3 = tab[r].f3; funct7_5 = tab[r].f7;
            flag_igual = tab[r].fi; flag_menor = tab[r].fm; flag_maior_igual_u = tab[r].fg;
            mem_ack = 1'b1;
            lat = 0; nwr = 0; pcs = 1'b0; ils = 1'b0;
            for (int c = 1; c <= 8 && lat == 0; c++) begin
                @(negedge clk);
                if (escreve_reg) nwr++;
                if (ilegal) ils = 1'b1;
                if (carrega_pc) begin lat = c; pcs = pc_src; end
                @(posedge clk);
                #1;
            end
            chk_int($sformatf("tab%0d_latency", r), lat, tab[r].lat);
            chk_int($sformatf("tab%0d_pc_src", r), int'(pcs), int'(tab[r].pcs));
            chk_int($sformatf("tab%0d_writes", r), nwr, tab[r].nwr);
            chk_int($sformatf("tab%0d_ilegal", r), int'(ils), int'(tab[r].il));
        end

        // ---------------- ld with 3 wait cycles in MEMORIA ----------------
        do_reset();
        opcode = 7'b0000011; funct3 = 3'd3; funct7_5 = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 9; c++) begin
            mem_ack = (c == 1 || c == 7) ? 1'b1 : (c >= 4 && c <= 6) ? 1'b0 : 1'($urandom);
            if (c == 9) mem_ack = 1'b0;
            @(negedge clk);
            if (mem_req && mem_addr_sel) cnt++;
            if (c == 8) begin
                e = '0; e.wr = 1'b1; e.wb = 2'd1; e.cpc = 1'b1; e.soma = 2'd1; e.imm = 1'b1;
                check("ld_wait_escrita", dut_out(), e);
            end
            if (c == 9) begin
                e = '0; e.req = 1'b1;
                check("ld_wait_back_to_busca", dut_out(), e);
            end
            @(posedge clk);
            #1;
        end
        chk_int("ld_wait_mem_cycles", cnt, 4);

        // ---------------- illegal opcode is sticky until reset ----------------
        do_reset();
        opcode = 7'b0000000; funct3 = 3'd0; funct7_5 = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cnt = 0;
        e = '0; e.il = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mem_ack = 1'($urandom);
            @(negedge clk);
            if (dut_out() === e) cnt++;
            @(posedge clk);
            #1;
        end
        chk_int("erro_sticky_cycles", cnt, 10);
        do_reset();
        mem_ack = 1'b0;
        @(negedge clk);
        e = '0; e.req = 1'b1;
        check("erro_cleared_by_reset", dut_out(), e);
        @(posedge clk); #1;

        // ---------------- reset in 2nd MEMORIA wait of sd ----------------
        do_reset();
        opcode = 7'b0100011; funct3 = 3'd3; funct7_5 = 1'b0;
        cpc_seen = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            mem_ack = (c == 1) ? 1'b1 : (c == 4) ? 1'b0 : 1'($urandom);
            @(negedge clk);
            if (carrega_pc) cpc_seen = 1'b1;
            @(posedge clk); #1;
        end
        reset = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        check("sd_abort_outputs_zero", dut_out(), '0);
        @(posedge clk); #1;
        reset = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        e = '0; e.req = 1'b1;
        check("sd_abort_next_busca", dut_out(), e);
        chk_int("sd_abort_no_carrega_pc", int'(cpc_seen), 0);
        @(posedge clk); #1;

        // ---------------- mem_ack never arrives in BUSCA ----------------
        do_reset();
        mem_ack = 1'b0;
        first = 0;
        cnt = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (ilegal && first == 0) first = c;
            if (c <= TO && mem_req) cnt++;
            if (c == 100) begin
                e = '0;
`ifdef UC_TIMEOUT_EN
                e.il = 1'b1;
`else
                e.req = 1'b1;
`endif
                check("timeout_cycle100", dut_out(), e);
            end
            @(posedge clk); #1;
        end
        chk_int("timeout_wait_req_cycles", cnt, TO);
`ifdef UC_TIMEOUT_EN
        chk_int("timeout_erro_cycle", first, TO + 1);
`else
        chk_int("timeout_never_erro", first, 0);
`endif

        // ---------------- randomized instruction stream ----------------
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                op = 7'($urandom); f3 = 3'($urandom); f7 = 1'($urandom);
            end else begin
                idx = $urandom_range(0, 8);
                op = enc_op[idx]; f3 = enc_f3[idx]; f7 = enc_f7[idx];
                if (idx == 8) f3 = 3'($urandom);
                if (idx > 1) f7 = 1'($urandom);
            end
            run_instr(i, op, f3, f7, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
